// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input handshake, a block enable,
// and a self-timed scan mode that walks the one-hot output with a programmable dwell.
module decoder_seq_n #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [(1<<N)-1:0]   dout,
  output logic                out_valid,
  output logic [N-1:0]        idx
);

  localparam int unsigned W        = 1 << N;
  localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StDec, StScan} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            accept;
  logic            resume;

  assign in_ready = en & ~mode & ~rst;
  assign accept   = in_valid & in_ready;
  // dout is only ever zero in DEC/SCAN after en was dropped, so it marks a resume.
  assign resume   = (dout == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dout      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (!en) begin
      // State and dwell count freeze; outputs blank.
      dout      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mode) begin
        if (state_q != StScan || resume) begin
          state_q <= StScan;
          cnt_q   <= '0;
          idx     <= '0;
          dout    <= W'(1);
        end else if (cnt_q == CntMax) begin
          cnt_q   <= '0;
          idx     <= idx + N'(1);
          dout    <= {dout[W-2:0], dout[W-1]};
        end else begin
          cnt_q   <= cnt_q + CW'(1);
        end
      end else if (accept) begin
        state_q   <= StDec;
        dout      <= W'(1) << sel;
        idx       <= sel;
        out_valid <= 1'b1;
      end else if (state_q == StScan) begin
        state_q <= StIdle;
        dout    <= '0;
        idx     <= '0;
      end else if (state_q == StDec && resume) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq_n.sv
// Bench for decoder_seq_n: an N=3/DWELL=4 and an N=4/DWELL=1 instance share control inputs
// and are checked every cycle against an elapsed-time reference model.
module tb_decoder_seq_n;

  logic        clk = 1'b0;
  logic        rst, en, mode, in_valid;
  logic [2:0]  sel_a;
  logic [3:0]  sel_b;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [7:0]  dout_a;
  logic [15:0] dout_b;
  logic [2:0]  idx_a;
  logic [3:0]  idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_seq_n #(.N(3), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .dout(dout_a), .out_valid(out_valid_a), .idx(idx_a)
  );

  decoder_seq_n #(.N(4), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .dout(dout_b), .out_valid(out_valid_b), .idx(idx_b)
  );

  // Model: kind 0 idle, 1 decoded, 2 scanning; scan position derived from elapsed cycles.
  typedef struct {
    int          kind;
    int          t;
    bit          paused;
    logic [63:0] dout;
    int          idx;
    bit          ov;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int n, int dw, bit r, bit e, bit md, bit iv, int s);
    mdl_t x = m;
    int   pos;
    if (r) begin
      x.kind = 0; x.t = 0; x.paused = 0; x.dout = 0; x.idx = 0; x.ov = 0;
    end else if (!e) begin
      x.dout = 0; x.idx = 0; x.ov = 0; x.paused = 1;
    end else begin
      x.ov = 0;
      if (md) begin
        if (m.kind != 2 || m.paused) begin
          x.kind = 2;
          x.t    = 0;
        end else begin
          x.t = m.t + 1;
        end
        pos    = (x.t / dw) % (1 << n);
        x.dout = 64'd1 << pos;
        x.idx  = pos;
      end else if (iv) begin
        x.kind = 1; x.dout = 64'd1 << s; x.idx = s; x.ov = 1;
      end else if (m.kind == 2 || m.paused) begin
        x.kind = 0; x.dout = 0; x.idx = 0;
      end
      x.paused = 0;
    end
    return x;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(bit r, bit e, bit md, bit iv, int sa, int sb);
    rst = r; en = e; mode = md; in_valid = iv;
    sel_a = 3'(sa); sel_b = 4'(sb);
    #1;
    chk("a.in_ready", in_ready_a, e & ~md & ~r);
    chk("b.in_ready", in_ready_b, e & ~md & ~r);
    @(posedge clk);
    ma = step(ma, 3, 4, r, e, md, iv, sa & 7);
    mb = step(mb, 4, 1, r, e, md, iv, sb & 15);
    #1;
    chk("a.dout", dout_a, ma.dout);
    chk("a.idx", idx_a, ma.idx);
    chk("a.out_valid", out_valid_a, ma.ov);
    chk("b.dout", dout_b, mb.dout);
    chk("b.idx", idx_b, mb.idx);
    chk("b.out_valid", out_valid_b, mb.ov);
  endtask

  typedef struct {
    bit       r, e, md, iv;
    int       s;
    bit [7:0] xd;
    bit       xov;
    int       xidx;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    bit   m_r;
    logic [15:0] eb;

    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel_a = '0; sel_b = '0;
    ma = '{kind: 0, t: 0, paused: 0, dout: 0, idx: 0, ov: 0};
    mb = ma;

    // Reset, decode sweep, hold, scan walk past one wrap (sel ignored while scanning).
    tbl.push_back('{r: 1, e: 0, md: 0, iv: 0, s: 0, xd: 8'h00, xov: 0, xidx: 0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{r: 0, e: 1, md: 0, iv: 1, s: i, xd: 8'(1 << i), xov: 1, xidx: i});
    tbl.push_back('{r: 0, e: 1, md: 0, iv: 1, s: 5, xd: 8'h20, xov: 1, xidx: 5});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{r: 0, e: 1, md: 0, iv: 0, s: i % 8, xd: 8'h20, xov: 0, xidx: 5});
    for (int k = 0; k < 36; k++)
      tbl.push_back('{r: 0, e: 1, md: 1, iv: 1, s: k % 8, xd: 8'(1 << ((k / 4) % 8)),
                      xov: 0, xidx: (k / 4) % 8});

    foreach (tbl[i]) begin
      v = tbl[i];
      cycle(v.r, v.e, v.md, v.iv, v.s, v.s);
      chk($sformatf("tbl[%0d].dout", i), dout_a, v.xd);
      chk($sformatf("tbl[%0d].out_valid", i), out_valid_a, v.xov);
      chk($sformatf("tbl[%0d].idx", i), idx_a, v.xidx);
    end

    // Enable gating at scan idx 3, then a full-dwell restart from position 0.
    for (int i = 0; i < 40 && ma.idx != 3; i++) cycle(0, 1, 1, 0, 0, 0);
    chk("gate.reach_idx3", idx_a, 3);
    cycle(0, 0, 1, 1, 1, 1);
    chk("gate.dout_off", dout_a, 8'h00);
    chk("gate.idx_off", idx_a, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 3, 3);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 1, 0, 0, 0);
      chk($sformatf("gate.restart[%0d]", k), dout_a, (k < 4) ? 8'h01 : 8'h02);
    end

    // Mode falls with a valid sel: accepted. Mode rises with a valid sel: scan wins.
    cycle(0, 1, 0, 1, 6, 6);
    chk("coll.accept_dout", dout_a, 8'h40);
    chk("coll.accept_ov", out_valid_a, 1);
    cycle(0, 1, 1, 1, 2, 2);
    chk("coll.scan_dout", dout_a, 8'h01);
    chk("coll.scan_ov", out_valid_a, 0);

    // Mid-scan reset on the DWELL=1 instance, then an every-cycle walk with wrap.
    for (int i = 0; i < 40 && mb.idx != 9; i++) cycle(0, 1, 1, 0, 0, 0);
    chk("rst.reach_idx9", idx_b, 9);
    cycle(1, 1, 1, 1, 4, 4);
    chk("rst.dout", dout_b, 16'h0000);
    chk("rst.idx", idx_b, 0);
    chk("rst.ov", out_valid_b, 0);
    for (int k = 0; k < 18; k++) begin
      cycle(0, 1, 1, 0, 0, 0);
      eb = 16'h0001 << (k % 16);
      chk($sformatf("walk[%0d]", k), dout_b, eb);
    end

    // Randomised traffic with sticky mode against the model.
    m_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) m_r = ~m_r;
      cycle($urandom_range(63) == 0, $urandom_range(7) != 0, m_r, $urandom_range(1) == 1,
            int'($urandom_range(7)), int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Registered, parametrised N-to-2^N one-hot decoder. It generalises the combinational 3-to-8 decoder with a valid/ready input handshake, an enable, and a self-timed scan mode. In scan mode the block walks its one-hot output through every position with a programmable dwell time. It drives row/digit-select strobes and one-hot register-file write enables in the datapath blocks.

Parameters:
N, 3, select width; output width is 2^N (N range 1..6)
DWELL, 4, clock cycles each one-hot position is held in scan mode (DWELL >= 1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  block enable; 0 forces outputs to zero and freezes internal counters
mode  input  1  0 = decode (handshaked), 1 = scan (free-running walk)
sel  input  N  select code to decode, qualified by in_valid
in_valid  input  1  sel is valid this cycle
in_ready  output  1  block accepts sel this cycle
dout  output  2^N  registered one-hot output
out_valid  output  1  one-cycle pulse: dout updated from an accepted sel
idx  output  N  binary index of the currently asserted dout bit (0 when dout is 0)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - dout = 0, out_valid = 0, idx = 0, in_ready = 0.
  - Dwell counter = 0; state = IDLE.
- States: IDLE, DEC, SCAN. All outputs are registered except in_ready, which is combinational from state/en/mode.
- in_ready = en & ~mode & ~rst. It is high in IDLE and DEC only.
- Accept: an accept happens when in_valid & in_ready. No back-pressure on the output side.
- IDLE:
  - dout = 0.
  - Accept -> DEC; next cycle dout = 1 << sel, idx = sel, out_valid = 1 (latency 1 cycle).
  - en & mode -> SCAN; next cycle dout = 1, idx = 0.
- DEC:
  - dout holds its last decoded value until a new accept.
  - New accept: dout/idx update next cycle, out_valid pulses.
  - Back-to-back accepts on consecutive cycles give consecutive updates, one out_valid pulse each.
  - Repeated identical sel still pulses out_valid.
  - en & mode -> SCAN, restarting at idx 0.
- SCAN:
  - The dwell counter counts 0..DWELL-1.
  - When it reaches DWELL-1, it clears and idx increments; dout = 1 << idx.
  - Wrap: idx 2^N-1 -> 0.
  - DWELL = 1 means idx advances every cycle.
  - out_valid stays 0 in SCAN.
  - sel/in_valid are ignored (in_ready = 0).
- mode 1 -> 0 while en = 1:
  - Next cycle state = IDLE, dout = 0, idx = 0.
  - in_ready rises combinationally the same cycle mode falls.
- en = 0:
  - Next cycle dout = 0, idx = 0, out_valid = 0.
  - State and dwell counter are held; in_ready = 0.
  - On en returning to 1:
    - SCAN resumes at idx 0 with dwell count 0.
    - DEC returns to IDLE (dout stays 0 until a new accept).
- Simultaneous events:
  - rst overrides everything.
  - en = 0 overrides mode and in_valid.
  - A mode change and in_valid in the same cycle: mode wins, because in_ready = 0 when mode = 1.
- Reset mid-operation: rst asserted at any time -> all reset values on the next edge. No partial output; the dwell count is discarded.
- Width rule: dout is always one-hot or all-zero. Exactly one bit is set when state is DEC or SCAN and en = 1.

Test Plan:
- Reset, then decode sweep: N = 3, mode = 0, en = 1, sel = 0..7 back-to-back with in_valid = 1 -> one cycle later dout = 8'h01, 02, 04 … 80 on consecutive cycles, out_valid high 8 cycles, idx = 0..7.
- Hold: accept sel = 5, then in_valid = 0 for 10 cycles -> dout stays 8'h20, out_valid pulses exactly once.
- Scan walk with DWELL = 4: mode = 1 -> dout = 8'h01 for 4 cycles, then 02, 04 …; after 32 cycles the sequence wraps back to 8'h01; in_ready = 0 throughout; out_valid never asserts.
- Enable gating: en = 0 during scan at idx = 3 -> dout = 0 next cycle; en = 1 -> scan restarts at dout = 8'h01 with a full 4-cycle dwell.
- Mode switch and collision: in the cycle mode goes 1 -> 0, drive in_valid = 1, sel = 6 -> accepted, dout = 8'h40 next cycle. mode 0 -> 1 with in_valid = 1, sel = 2 -> not accepted, dout = 8'h01.
- Mid-operation reset, plus parameter check at N = 4, DWELL = 1: rst at scan idx = 9 -> next cycle dout = 0, idx = 0, out_valid = 0. Scan after release gives 16'h0001, 0002 … advancing every cycle and wrapping after 16.
